// File: rtl/dram_uart_tx_if.sv
// Control and DRAM read-port signals for the DRAM-to-UART block transmitter.
// The slave modport is the transmitter; the master side is the controller plus memory.
interface dram_uart_tx_if #(
    parameter int ADDR_W = 20
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] num_bytes;
    logic [ADDR_W-1:0] dm_addr;
    logic              dm_rden;
    logic [7:0]        dm_q;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, num_bytes, dm_q,
        input  dm_addr, dm_rden, tx, busy, done
    );

    modport slave (
        input  start, base_addr, num_bytes, dm_q,
        output dm_addr, dm_rden, tx, busy, done
    );
endinterface

// File: rtl/dram_uart_tx.sv
// Reads num_bytes bytes from DRAM starting at base_addr and sends each one
// as an 8N1 UART frame, LSB first. All outputs are registered.
module dram_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 20,
    parameter int READ_LAT     = 2
) (
    input logic           clock,
    input logic           reset,
    dram_uart_tx_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_DATA, S_STOP, S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic [CNT_W-1:0]  bit_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;

    // NOTE: every register here, outputs included, is state of one clocked
    // process, so all assignments are non-blocking and all get a reset value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            addr        <= '0;
            remaining   <= '0;
            bit_cnt     <= '0;
            lat_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            bus.dm_addr <= '0;
            bus.dm_rden <= 1'b0;
            bus.tx      <= 1'b1;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.dm_rden <= 1'b0;
            bus.done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus.tx   <= 1'b1;
                    bus.busy <= 1'b0;
                    if (bus.start) begin
                        addr      <= bus.base_addr;
                        remaining <= bus.num_bytes;
                        if (bus.num_bytes == '0) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state       <= S_FETCH;
                            bus.busy    <= 1'b1;
                            bus.dm_rden <= 1'b1;
                            bus.dm_addr <= bus.base_addr;
                            lat_cnt     <= '0;
                        end
                    end
                end

                S_FETCH: begin
                    // Read data is valid on the last of the READ_LAT fetch cycles.
                    if (lat_cnt == LAT_LAST) begin
                        shreg   <= bus.dm_q;
                        bus.tx  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= S_START;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                S_START: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        bus.tx  <= shreg[0];
                        state   <= S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bus.tx <= 1'b1;
                            state  <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            bus.tx  <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt   <= '0;
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - ADDR_W'(1);
                        if (remaining == ADDR_W'(1)) begin
                            state    <= S_DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            state       <= S_FETCH;
                            bus.dm_rden <= 1'b1;
                            bus.dm_addr <= addr + ADDR_W'(1);
                            lat_cnt     <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_uart_tx.sv
// Scoreboard bench for dram_uart_tx: the driver pushes expected read addresses,
// bytes and done times; independent monitors decode the line and compare.
module tb_dram_uart_tx;
    localparam int C      = 4;
    localparam int RL     = 2;
    localparam int AW     = 20;
    localparam int FRAME  = RL + 10 * C;

    logic clock;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errors;

    dram_uart_tx_if #(.ADDR_W(AW)) bus ();

    dram_uart_tx #(
        .CLKS_PER_BIT(C),
        .ADDR_W      (AW),
        .READ_LAT    (RL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    logic [7:0]    mem [logic [AW-1:0]];
    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    exp_byte_q[$];
    int            exp_done_q[$];
    int            busy_from;
    int            busy_until;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Memory: data valid in the cycle after the enable cycle, garbage otherwise.
    always @(posedge clock)
        bus.dm_q <= bus.dm_rden ? mem[bus.dm_addr] : 8'($urandom);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Read-address monitor.
    always @(negedge clock) begin
        if (!reset && bus.dm_rden) begin
            check("rd_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) check("rd_addr", 32'(bus.dm_addr), 32'(exp_addr_q.pop_front()));
        end
    end

    // Done-timing monitor.
    always @(negedge clock) begin
        if (!reset && bus.done) begin
            check("done_expected", 32'(exp_done_q.size() != 0), 32'd1);
            if (exp_done_q.size() != 0) check("done_cycle", 32'(cyc), 32'(exp_done_q.pop_front()));
        end
    end

    // Busy window monitor.
    always @(negedge clock) begin
        if (!reset) check("busy", 32'(bus.busy), 32'(cyc >= busy_from && cyc < busy_until));
    end

    // UART receiver: mid-bit sampling from the first low sample of a start bit.
    bit         rx_active;
    int         rx_off;
    logic [7:0] rx_byte;
    always @(negedge clock) begin
        if (reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (bus.tx === 1'b0) begin
                rx_active = 1'b1;
                rx_off    = 0;
            end
        end else begin
            rx_off++;
            if (rx_off % C == C / 2) begin
                if (rx_off / C == 0) begin
                    check("rx_start_bit", 32'(bus.tx), 32'd0);
                end else if (rx_off / C <= 8) begin
                    rx_byte[rx_off / C - 1] = bus.tx;
                end else begin
                    check("rx_stop_bit", 32'(bus.tx), 32'd1);
                    check("rx_frame_expected", 32'(exp_byte_q.size() != 0), 32'd1);
                    if (exp_byte_q.size() != 0) check("rx_byte", 32'(rx_byte), 32'(exp_byte_q.pop_front()));
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [AW-1:0] base, input int n);
        int e0;
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = base + AW'(i);
            if (!mem.exists(a)) mem[a] = 8'($urandom);
            exp_addr_q.push_back(a);
            exp_byte_q.push_back(mem[a]);
        end
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.num_bytes = AW'(n);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        e0 = cyc;
        exp_done_q.push_back(e0 + n * FRAME);
        if (n > 0) begin
            busy_from  = e0;
            busy_until = e0 + n * FRAME;
        end
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (exp_done_q.size() != 0 && k < limit) begin
            @(negedge clock);
            k++;
        end
        check("done_timeout", 32'(exp_done_q.size()), 32'd0);
        check("bytes_left", 32'(exp_byte_q.size()), 32'd0);
        check("reads_left", 32'(exp_addr_q.size()), 32'd0);
        exp_done_q.delete();
        exp_byte_q.delete();
        exp_addr_q.delete();
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        cyc           = 0;
        n_checks      = 0;
        n_errors      = 0;
        busy_from     = 0;
        busy_until    = 0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_bytes = '0;
        reset         = 1'b0;
        #1 reset = 1'b1;

        // Reset state, then a long idle stretch watched by the monitors.
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rden", 32'(bus.dm_rden), 32'd0);
        check("rst_addr", 32'(bus.dm_addr), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (100) @(negedge clock);
        check("idle_tx", 32'(bus.tx), 32'd1);

        // Single byte with exact line waveform.
        mem[20'h00010] = 8'hA5;
        send(20'h00010, 1);
        pat = 8'hA5;
        repeat (RL) @(posedge clock);
        for (int i = 0; i < 10 * C; i++) begin
            logic exp_bit;
            int   b;
            b = i / C;
            exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : pat[b - 1];
            @(negedge clock);
            check("wave_a5", 32'(bus.tx), 32'(exp_bit));
        end
        wait_done(FRAME + 20);

        // Multi-byte across the address wrap.
        mem[20'hFFFFE] = 8'h11;
        mem[20'hFFFFF] = 8'h22;
        mem[20'h00000] = 8'h33;
        send(20'hFFFFE, 3);
        wait_done(3 * FRAME + 20);

        // Zero length: immediate done, no read, line stays high.
        send(20'h00200, 0);
        wait_done(10);
        check("zero_tx", 32'(bus.tx), 32'd1);

        // Start while busy is ignored.
        send(20'h00100, 2);
        repeat (RL + C + 2 * C) @(posedge clock);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = 20'h55555;
        bus.num_bytes = 20'd3;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        wait_done(2 * FRAME + 20);

        // Reset during the fourth data bit aborts without done.
        send(20'h00300, 1);
        repeat (RL + C + 3 * C + 2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_tx", 32'(bus.tx), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        exp_done_q.delete();
        exp_byte_q.delete();
        exp_addr_q.delete();
        busy_until = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        send(20'h0ABCD, 2);
        wait_done(2 * FRAME + 20);

        // Randomized blocks from random bases with random idle gaps.
        for (int t = 0; t < 5; t++) begin
            int n;
            n = int'($urandom_range(1, 3));
            repeat ($urandom_range(0, 5)) @(negedge clock);
            send(AW'($urandom), n);
            wait_done(n * FRAME + 20);
        end

        repeat (20) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dram_uart_tx.md
# dram_uart_tx

Streams a contiguous block of bytes out of the 8-bit data DRAM as an 8N1 UART serial frame sequence. It is the transmit-side counterpart of the UART receiver that loads the input image into DRAM. It sits beside the processor: once the processor raises end of processing, the main controller pulses `start` to send the downsampled result back to the host. It owns the DRAM read port (address mux select) only while `busy` is high.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); legal values ≥ 2.
- `ADDR_W`, 20: DRAM address width.
- `READ_LAT`, 2: cycles from `dm_rden` assertion to valid `dm_q`; legal values ≥ 1.

Ports:
- `clock` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `base_addr` in ADDR_W: first DRAM address; captured on accepted `start`.
- `num_bytes` in ADDR_W: number of bytes to send; captured on accepted `start`.
- `dm_addr` out ADDR_W: DRAM read address.
- `dm_rden` out 1: DRAM read enable.
- `dm_q` in 8: DRAM read data.
- `tx` out 1: serial output; idle level is high.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at the end of the block.

## Operation
- States: IDLE, FETCH, START, DATA, STOP, DONE.
- IDLE:
  - `tx`=1, `busy`=0.
  - When `start`=1, capture `base_addr` into the address register and `num_bytes` into the remaining-count register.
  - If the captured count is 0, go to DONE. Otherwise go to FETCH.
- FETCH:
  - Lasts exactly READ_LAT cycles.
  - `dm_rden`=1 only in the first cycle; `dm_addr` holds the address register throughout.
  - On the last FETCH edge, load `dm_q` into the 8-bit shift register and go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bit periods, LSB first. Each bit is held for CLKS_PER_BIT cycles; a 3-bit counter tracks the bit index.
- STOP:
  - `tx`=1 for CLKS_PER_BIT cycles.
  - At the end of STOP, increment the address register (wraps modulo 2^ADDR_W) and decrement the count.
  - If the count is now 0, go to DONE. Otherwise go to FETCH.
- DONE: `done`=1 and `busy`=0 for one cycle, then go to IDLE.
- `start` while not in IDLE is ignored. It is not queued.
- The bit-period counter is ceil(log2(CLKS_PER_BIT)) bits wide. It resets to 0 on every state entry and on every bit boundary.
- Reset mid-operation aborts immediately: `tx` returns high, state goes to IDLE, and no `done` pulse is produced.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `dm_rden`=0, `dm_addr`=0. All internal registers are 0 and state is IDLE.
- All outputs are registered, so there is no combinational path from inputs to outputs.
- `start` accepted at edge E0: FETCH is active from E0. `busy` rises at E0, and `dm_rden` is high in cycle E0..E1.
- The start bit begins READ_LAT cycles after E0.
- Per byte: READ_LAT + 10·CLKS_PER_BIT cycles. Between frames, the line is high for READ_LAT cycles (the FETCH gap).
- With N ≥ 1 bytes, `done` is high exactly N·(READ_LAT + 10·CLKS_PER_BIT) cycles after E0.
- With N = 0, `done` is high in the cycle after E0 and `tx` never drops.
- `dm_addr` is stable for the whole FETCH state. Outside FETCH, it holds the last address.
- `busy` stays high continuously from E0 until the `done` cycle, across all byte boundaries.

## Test plan
Simulate with CLKS_PER_BIT=4 and READ_LAT=2.
1. Reset behaviour: hold `reset` for 3 cycles, then release -> `tx`=1, `busy`=0, `done`=0, `dm_rden`=0 throughout; no activity for 100 cycles without `start`.
2. Single byte: DRAM[0x00010]=0xA5, `base_addr`=0x00010, `num_bytes`=1 -> `dm_rden` pulse with `dm_addr`=0x00010. `tx` shows 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. `done` occurs 42 cycles after start.
3. Multi-byte and wrap: `base_addr`=0xFFFFE, `num_bytes`=3, DRAM holds 0x11, 0x22, 0x33 at 0xFFFFE, 0xFFFFF, 0x00000 -> receiver model decodes 0x11, 0x22, 0x33. Reads go to 0xFFFFE, 0xFFFFF, then 0x00000. `done` occurs at 126 cycles.
4. Zero length: `num_bytes`=0 -> `done` in the next cycle, no `dm_rden`, `tx` stays high.
5. Start while busy: pulse `start` again mid-DATA with different `base_addr` -> ignored; the original transfer completes unchanged with a single `done`.
6. Reset mid-frame: assert `reset` during the 4th data bit -> `tx`=1 and `busy`=0 immediately (asynchronous); no `done`. A subsequent `start` transmits correctly from the new `base_addr`.
